data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Target (responder) end of the core's data-memory port.
- Serves word reads and writes issued on mem_addr / mem_data_in / mem_write_en and returns read data on mem_data_out.
- Models a multi-cycle memory: fixed configurable latency, request/ready handshake, busy indication.
- Lets the core and later pipelined cores be exercised against non-zero memory latency.

Parameters:
- ADDR_WIDTH, 12, byte-address width of the implemented space; depth = 2**(ADDR_WIDTH-2) words.
- LATENCY, 4, cycles from request acceptance to completion; legal range 1..15.

Ports:
- clk  input  1  clock, rising-edge.
- rst_b  input  1  reset, asynchronous, active-low.
- mem_req  input  1  access request, sampled only in IDLE.
- mem_addr  input  32  byte address of the access.
- mem_write_en  input  1  1 = write, 0 = read; sampled with mem_req.
- mem_data_in  input  4x8 ([0:3])  write data; lane 0 = bits 31:24 (big-endian).
- mem_data_out  output  4x8 ([0:3])  read data, registered; lane 0 = bits 31:24.
- mem_ready  output  1  one-cycle completion pulse.
- mem_err  output  1  one-cycle error pulse, coincident with mem_ready.
- mem_busy  output  1  high while an access is in flight.

Behaviour:
- Reset (rst_b low, asynchronous):
  - state = IDLE; mem_ready, mem_err and mem_busy = 0; mem_data_out = 0; latency counter = 0.
  - Array contents are not reset.
- States: IDLE, BUSY.
- IDLE:
  - On a rising edge with mem_req = 1, latch addr, write_en and data into request registers.
  - Load counter with LATENCY-1 and go to BUSY.
  - mem_req = 0 keeps IDLE.
- BUSY:
  - Each edge with counter != 0 decrements the counter.
  - On the edge with counter == 0, perform the access and return to IDLE.
  - That edge also sets mem_ready = 1 for exactly one cycle.
- Latency: request accepted at edge E0 gives mem_ready high in the cycle after edge E0+LATENCY. Example: LATENCY = 1 means ready follows the next edge.
- mem_busy = (state == BUSY), combinational from the state register.
- mem_req while BUSY is ignored; it is not queued. Inputs changing while BUSY have no effect, because the latched copies are used.
- A new request may be accepted at the edge ending the mem_ready cycle. Minimum back-to-back period is LATENCY+1 cycles.
- Write completion:
  - Array word at latched addr[ADDR_WIDTH-1:2] takes the latched {lane0, lane1, lane2, lane3}.
  - mem_data_out is unchanged.
- Read completion: mem_data_out takes the array word. It holds that value until the next successful or erroring read completes.
- Error conditions (checked on latched values): addr[1:0] != 0, or any of addr[31:ADDR_WIDTH] nonzero. On error:
  - mem_err pulses together with mem_ready.
  - A write is dropped (array unchanged).
  - A read drives mem_data_out = 0.
- Read-after-write to the same word returns the new data (write committed before the next acceptance).
- Reset mid-access: the access is aborted, no write commits, and no ready pulse follows reset release.

Decomposition:
- Shared package mem_pkg:
  - state enum mem_state_t {IDLE, BUSY}.
  - byte_lanes_t (4x8 unpacked lane type).
  - Helper functions pack_lanes / unpack_lanes, lane 0 = MSB.
- One sub-module: mem_bank, a synchronous single-port word array with we, word index, wdata in and registered rdata out. It contains no reset logic.
- The responder holds the FSM, counter, request registers and error check.

Test Plan:
- Reset then write 0xDEADBEEF to 0x010, LATENCY = 4: mem_busy high for 4 cycles, mem_ready pulses once after the 4th edge, mem_err = 0.
- Read 0x010 after that write: mem_data_out[0..3] = DE, AD, BE, EF on the mem_ready cycle; value holds through a later write to 0x020.
- Second mem_req asserted and addr/data changed while BUSY: ignored, only the first access completes; a request held during the ready cycle is accepted at the next edge, giving a LATENCY+1 period.
- Read 0x013 (misaligned) and read 0x1000 (out of range, ADDR_WIDTH = 12): mem_err and mem_ready pulse together, mem_data_out = 0. Write to 0x1000 is dropped: a subsequent read of 0x000 is unchanged.
- Write 0x12345678 to 0x040, pull rst_b low at counter = 1, release: no mem_ready, busy = 0. Read of 0x040 returns the prior contents (first preload 0x0 via a completed write).
- LATENCY = 1 build: write then read of 0x004 gives ready one edge after each acceptance; read returns the written data.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared types and lane helpers for the data-memory responder.
// Lane 0 carries the most significant byte (big-endian).
package mem_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mem_state_t;

   typedef logic [7:0] byte_lanes_t [0:3];

   localparam int unsigned LAT_W = 4;

   function automatic logic [31:0] pack_lanes(input byte_lanes_t l);
      return {l[0], l[1], l[2], l[3]};
   endfunction

   function automatic byte_lanes_t unpack_lanes(input logic [31:0] w);
      byte_lanes_t l;
      for (int i = 0; i < 4; i++) begin
         l[i] = w[31-8*i -: 8];
      end
      return l;
   endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Data-memory port between the core (master) and the memory responder (slave).
interface data_mem_responder_if;
   import mem_pkg::*;

   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_write_en;
   byte_lanes_t mem_data_in;
   byte_lanes_t mem_data_out;
   logic        mem_ready;
   logic        mem_err;
   logic        mem_busy;

   modport master (
      output mem_req, mem_addr, mem_write_en, mem_data_in,
      input  mem_data_out, mem_ready, mem_err, mem_busy
   );

   modport slave (
      input  mem_req, mem_addr, mem_write_en, mem_data_in,
      output mem_data_out, mem_ready, mem_err, mem_busy
   );

endinterface

// File: rtl/data_mem_responder_bank.sv
// Synchronous single-port word array with a registered read port.
// Contents are deliberately left unreset.
module mem_bank #(
   parameter int unsigned IDX_W = 10
) (
   input  logic             clk,
   input  logic             we,
   input  logic [IDX_W-1:0] idx,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata
);

   logic [31:0] mem_q [2**IDX_W];
   logic [31:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[idx] <= wdata;
      end
      rdata_q <= mem_q[idx];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency data-memory responder: accepts one request in IDLE, counts
// LATENCY edges in BUSY, then commits the access and pulses mem_ready.
module data_mem_responder
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 12,
   parameter int unsigned LATENCY    = 4
) (
   input  logic                 clk,
   input  logic                 rst_b,
   data_mem_responder_if.slave  bus
);

   localparam int unsigned IDX_W = ADDR_WIDTH - 2;

   mem_state_t       state_q, state_d;
   logic [LAT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      addr_q, addr_d;
   logic             we_q, we_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [31:0]      dout_q, dout_d;
   logic             ready_q, ready_d;
   logic             err_q, err_d;

   logic             addr_err;
   logic             done;
   logic             bank_we;
   logic [IDX_W-1:0] bank_idx;
   logic [31:0]      bank_rdata;

   assign addr_err = (addr_q[1:0] != 2'b00) || ((addr_q >> ADDR_WIDTH) != 32'd0);
   assign done     = (state_q == BUSY) && (cnt_q == '0);
   assign bank_we  = done && we_q && !addr_err;

   // In IDLE the bank already reads the incoming address so that read data is
   // ready by the completion edge even for single-cycle latency.
   assign bank_idx = (state_q == IDLE) ? bus.mem_addr[ADDR_WIDTH-1:2]
                                       : addr_q[ADDR_WIDTH-1:2];

   mem_bank #(.IDX_W(IDX_W)) u_bank (
      .clk   (clk),
      .we    (bank_we),
      .idx   (bank_idx),
      .wdata (wdata_q),
      .rdata (bank_rdata)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      dout_d  = dout_q;
      ready_d = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.mem_req) begin
               addr_d  = bus.mem_addr;
               we_d    = bus.mem_write_en;
               wdata_d = pack_lanes(bus.mem_data_in);
               cnt_d   = LAT_W'(LATENCY - 1);
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               state_d = IDLE;
               ready_d = 1'b1;
               err_d   = addr_err;
               if (!we_q) begin
                  dout_d = addr_err ? 32'd0 : bank_rdata;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dout_q  <= '0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
         ready_q <= ready_d;
         err_q   <= err_d;
      end
   end

   // Request copies are only meaningful while BUSY, so they carry no reset.
   always_ff @(posedge clk) begin
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
   end

   assign bus.mem_ready = ready_q;
   assign bus.mem_err   = err_q;
   assign bus.mem_busy  = (state_q == BUSY);

   always_comb begin
      bus.mem_data_out = unpack_lanes(dout_q);
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized and directed bench for data_mem_responder (LATENCY 4 and 1 builds)
// against a word-level reference model.
module tb_data_mem_responder;
   import mem_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst4_b;
   logic rst1_b;

   data_mem_responder_if if4 ();
   data_mem_responder_if if1 ();

   data_mem_responder #(.ADDR_WIDTH(12), .LATENCY(4)) dut4 (
      .clk   (clk),
      .rst_b (rst4_b),
      .bus   (if4.slave)
   );

   data_mem_responder #(.ADDR_WIDTH(12), .LATENCY(1)) dut1 (
      .clk   (clk),
      .rst_b (rst1_b),
      .bus   (if1.slave)
   );

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model: one word store per DUT, keyed by sel*4096 + word index.
   logic [31:0] ref_mem [int unsigned];
   logic [31:0] last_rd [2];
   bit          last_ok [2];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic drive(input virtual data_mem_responder_if v, input bit req, input bit we,
                        input logic [31:0] a, input logic [31:0] d);
      v.mem_req      = req;
      v.mem_write_en = we;
      v.mem_addr     = a;
      for (int i = 0; i < 4; i++) v.mem_data_in[i] = d[31-8*i -: 8];
   endtask

   function automatic logic [31:0] dout_word(input virtual data_mem_responder_if v);
      return {v.mem_data_out[0], v.mem_data_out[1], v.mem_data_out[2], v.mem_data_out[3]};
   endfunction

   function automatic bit is_err(input logic [31:0] a);
      return (a[1:0] != 2'b00) || (a[31:12] != 20'd0);
   endfunction

   // One complete access; optional noise keeps a different request asserted
   // while BUSY, which must have no effect.
   task automatic xact(input int sel, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit noise, output logic [31:0] rd);
      virtual data_mem_responder_if v;
      int          lat;
      int          k;
      int          busy_cnt;
      bit          err_exp;
      int unsigned key;
      logic [31:0] exp_d;
      bit          exp_ok;
      if (sel == 1) begin v = if1; lat = 1; end
      else begin v = if4; lat = 4; end
      err_exp = is_err(addr);
      key     = sel * 4096 + addr[11:2];
      @(negedge clk);
      drive(v, 1'b1, we, addr, wdata);
      @(posedge clk); #1;
      if (noise) drive(v, 1'b1, ~we, addr ^ 32'h0000_0ff0, ~wdata);
      else v.mem_req = 1'b0;
      k        = 0;
      busy_cnt = 0;
      if (v.mem_busy === 1'b1) busy_cnt++;
      for (int c = 1; c <= 20 && k == 0; c++) begin
         @(posedge clk); #1;
         if (v.mem_ready === 1'b1) k = c;
         else if (v.mem_busy === 1'b1) busy_cnt++;
      end
      v.mem_req = 1'b0;
      check("latency", k, lat);
      check("busy_cycles", busy_cnt, lat);
      check("busy_at_ready", v.mem_busy, 1'b0);
      check("err", v.mem_err, err_exp);
      if (we) begin
         if (!err_exp) ref_mem[key] = wdata;
         exp_d  = last_rd[sel];
         exp_ok = last_ok[sel];
      end else begin
         exp_ok = 1'b1;
         if (err_exp) exp_d = 32'd0;
         else if (ref_mem.exists(key)) exp_d = ref_mem[key];
         else begin exp_d = 32'd0; exp_ok = 1'b0; end
         last_rd[sel] = exp_d;
         last_ok[sel] = exp_ok;
      end
      rd = dout_word(v);
      if (exp_ok) check(we ? "dout_hold" : "read_data", rd, exp_d);
      @(posedge clk); #1;
      check("ready_pulse", v.mem_ready, 1'b0);
      check("err_pulse", v.mem_err, 1'b0);
   endtask

   logic [31:0] rd;
   logic [31:0] pool [8];
   int          t_a;
   int          t_b;
   int          pulses;

   initial begin
      drive(if4, 1'b0, 1'b0, 32'd0, 32'd0);
      drive(if1, 1'b0, 1'b0, 32'd0, 32'd0);
      rst4_b = 1'b0;
      rst1_b = 1'b0;
      last_rd[0] = 32'd0; last_ok[0] = 1'b1;
      last_rd[1] = 32'd0; last_ok[1] = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", if4.mem_ready, 1'b0);
      check("rst_err", if4.mem_err, 1'b0);
      check("rst_busy", if4.mem_busy, 1'b0);
      check("rst_dout", dout_word(if4), 32'd0);
      check("rst_dout_l1", dout_word(if1), 32'd0);
      @(negedge clk);
      rst4_b = 1'b1;
      rst1_b = 1'b1;

      // Basic write/read with lane order and hold across a later write
      xact(0, 1'b1, 32'h010, 32'hDEAD_BEEF, 1'b0, rd);
      xact(0, 1'b0, 32'h010, 32'd0, 1'b0, rd);
      check("lane0", if4.mem_data_out[0], 8'hDE);
      check("lane1", if4.mem_data_out[1], 8'hAD);
      check("lane2", if4.mem_data_out[2], 8'hBE);
      check("lane3", if4.mem_data_out[3], 8'hEF);
      xact(0, 1'b1, 32'h020, 32'h0BAD_F00D, 1'b1, rd);
      check("hold_after_write", dout_word(if4), 32'hDEAD_BEEF);

      // Request held through BUSY is ignored, then accepted after the ready cycle
      @(negedge clk);
      drive(if4, 1'b1, 1'b1, 32'h030, 32'hA5A5_5A5A);
      @(posedge clk); #1;
      drive(if4, 1'b1, 1'b0, 32'h030, 32'hFFFF_FFFF);
      t_a = 0;
      t_b = 0;
      for (int c = 1; c <= 30 && t_b == 0; c++) begin
         @(posedge clk); #1;
         if (t_a != 0 && c == t_a + 1) begin
            if4.mem_req = 1'b0;
            check("b2b_accept_busy", if4.mem_busy, 1'b1);
         end
         if (if4.mem_ready === 1'b1) begin
            if (t_a == 0) t_a = c;
            else t_b = c;
         end
      end
      if4.mem_req = 1'b0;
      check("b2b_first_ready", t_a, 4);
      check("b2b_second_ready", t_b, 9);
      check("b2b_read_data", dout_word(if4), 32'hA5A5_5A5A);
      ref_mem[32'h030 >> 2] = 32'hA5A5_5A5A;
      last_rd[0] = 32'hA5A5_5A5A;
      @(posedge clk); #1;

      // Error cases: misaligned, out of range, dropped write aliasing word 0
      xact(0, 1'b1, 32'h000, 32'h1111_2222, 1'b0, rd);
      xact(0, 1'b0, 32'h013, 32'd0, 1'b0, rd);
      xact(0, 1'b0, 32'h010, 32'd0, 1'b0, rd);
      xact(0, 1'b0, 32'h1000, 32'd0, 1'b0, rd);
      check("oor_read_zero", dout_word(if4), 32'd0);
      xact(0, 1'b1, 32'h1000, 32'hCAFE_CAFE, 1'b0, rd);
      xact(0, 1'b0, 32'h000, 32'd0, 1'b0, rd);
      check("dropped_write", rd, 32'h1111_2222);

      // Reset in the middle of a write with one count remaining
      xact(0, 1'b1, 32'h040, 32'h0000_0000, 1'b0, rd);
      @(negedge clk);
      drive(if4, 1'b1, 1'b1, 32'h040, 32'h1234_5678);
      @(posedge clk); #1;
      if4.mem_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst4_b = 1'b0;
      #1;
      check("midrst_busy", if4.mem_busy, 1'b0);
      check("midrst_ready", if4.mem_ready, 1'b0);
      check("midrst_dout", dout_word(if4), 32'd0);
      last_rd[0] = 32'd0;
      @(negedge clk);
      rst4_b = 1'b1;
      pulses = 0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         if (if4.mem_ready !== 1'b0 || if4.mem_busy !== 1'b0) pulses++;
      end
      check("midrst_no_ready", pulses, 0);
      xact(0, 1'b0, 32'h040, 32'd0, 1'b0, rd);
      check("midrst_no_commit", rd, 32'd0);

      // Single-cycle latency build
      xact(1, 1'b1, 32'h004, 32'h5566_7788, 1'b0, rd);
      xact(1, 1'b0, 32'h004, 32'd0, 1'b0, rd);
      check("l1_read", rd, 32'h5566_7788);

      // Randomized traffic over a preloaded pool of words
      for (int i = 0; i < 8; i++) begin
         pool[i] = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
         xact(0, 1'b1, pool[i], $urandom, 1'b0, rd);
         xact(1, 1'b1, pool[i], $urandom, 1'b0, rd);
      end
      for (int i = 0; i < 40; i++) begin
         logic [31:0] a;
         int          r;
         int          sel;
         r   = $urandom_range(0, 9);
         sel = (i % 4 == 3) ? 1 : 0;
         a   = pool[$urandom_range(0, 7)];
         if (r == 0) a = a | 32'($urandom_range(1, 3));
         else if (r == 1) a = a | (32'd1 << $urandom_range(12, 31));
         xact(sel, 1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)), rd);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
